// File: rtl/memory_arbiter_pkg.sv
// Shared types for the byte-wide memory port arbiter:
// FSM states, load/store size codes and the IO region decode.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // ls_addr[17:16] value that selects memory-mapped IO
  localparam logic [1:0] IO_REGION = 2'b11;

  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  // The illegal code 11 is treated as a word.
  function automatic logic [2:0] size_len(input logic [1:0] size);
    unique case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Single owner of the byte-wide RAM/IO port: arbitrates icache and
// LSB requests and serialises them into little-endian byte transfers.
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        flush,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [2:0]  len, len_n;
  logic [31:0] addr, addr_n;
  logic [31:0] wdata, wdata_n;
  logic [31:0] rbuf, rbuf_n;
  logic        io_st, io_st_n;
  logic        last_grant, last_grant_n;
  logic        ic_done_n, ls_done_n;
  logic [31:0] ic_data_n, ls_rdata_n;

  logic        busy;
  logic        ic_go;
  logic        ls_go;
  logic        pick_ls;
  logic        stall;
  logic        active;
  logic [1:0]  bidx;

  assign busy    = ic_done | ls_done;
  assign ic_go   = ic_req & ~busy & ~flush;
  assign ls_go   = ls_req & ~busy & ~flush;
  assign pick_ls = ls_go & (~ic_go | (last_grant == GRANT_IC));
  assign active  = (state != IDLE) && (cnt < len);
  assign stall   = (state == DWRITE) && (cnt == 3'd0)
                 && io_st && io_buffer_full;
  // byte returned this cycle belongs to the address issued last cycle
  assign bidx    = cnt[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      addr       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      io_st      <= 1'b0;
      last_grant <= GRANT_IC;
      ic_done    <= 1'b0;
      ls_done    <= 1'b0;
      ic_data    <= '0;
      ls_rdata   <= '0;
    end else if (rdy) begin
      state      <= state_n;
      cnt        <= cnt_n;
      len        <= len_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      rbuf       <= rbuf_n;
      io_st      <= io_st_n;
      last_grant <= last_grant_n;
      ic_done    <= ic_done_n;
      ls_done    <= ls_done_n;
      ic_data    <= ic_data_n;
      ls_rdata   <= ls_rdata_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    len_n        = len;
    addr_n       = addr;
    wdata_n      = wdata;
    rbuf_n       = rbuf;
    io_st_n      = io_st;
    last_grant_n = last_grant;
    ic_done_n    = 1'b0;
    ls_done_n    = 1'b0;
    ic_data_n    = ic_data;
    ls_rdata_n   = ls_rdata;
    unique case (state)
      IDLE: begin
        if (pick_ls) begin
          addr_n       = ls_addr;
          len_n        = size_len(ls_size);
          wdata_n      = ls_wdata;
          io_st_n      = (ls_addr[17:16] == IO_REGION);
          last_grant_n = GRANT_LS;
          cnt_n        = '0;
          rbuf_n       = '0;
          state_n      = ls_we ? DWRITE : DREAD;
        end else if (ic_go) begin
          addr_n       = ic_addr;
          len_n        = 3'd4;
          io_st_n      = 1'b0;
          last_grant_n = GRANT_IC;
          cnt_n        = '0;
          rbuf_n       = '0;
          state_n      = IFETCH;
        end
      end
      IFETCH, DREAD: begin
        if (flush) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          if (cnt != 3'd0) begin
            rbuf_n[{bidx, 3'b000} +: 8] = mem_din;
          end
          if (cnt == len) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == IFETCH) begin
              ic_done_n = 1'b1;
              ic_data_n = rbuf_n;
            end else begin
              ls_done_n  = 1'b1;
              ls_rdata_n = rbuf_n;
            end
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      DWRITE: begin
        // stores are committed, so flush is not looked at here
        if (!stall) begin
          if (cnt == len - 3'd1) begin
            state_n   = IDLE;
            cnt_n     = '0;
            ls_done_n = 1'b1;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (active) begin
      mem_a = addr + {29'd0, cnt};
    end
    if (active && (state == DWRITE)) begin
      mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
      mem_wr   = ~stall;
    end
  end

endmodule
